// File: rtl/seg_scan_driver.sv
//------------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexes four hex/BCD digits onto one shared 7-segment bus with
// per-digit anode enables. Upstream presents a 16-bit digit word and a
// decimal-point mask with a one-cycle load strobe. The word is double-buffered:
// loads land in a pending buffer and are promoted to the active buffer only at
// a frame boundary, so a frame never mixes old and new digits.
//
// Each digit slot lasts CLK_DIV cycles. The first BLANK_CYC cycles of every
// slot are dead-time with all anodes off, which prevents ghosting while the
// segment bus switches between digits.
//
// Parameters:
//   CLK_DIV        clock cycles per digit slot (must exceed BLANK_CYC)
//   BLANK_CYC      dead-time cycles at the start of each slot (>= 1)
//   SEG_ACTIVE_LOW 1: lit segment driven as 0 (common anode), 0: lit = 1
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   digits  in   [15:0] nibble k = digits[4k+3:4k], digit0 rightmost
//   dp      in   [3:0]  decimal-point request, bit k for digit k
//   load    in   strobe capturing {dp,digits} into the pending buffer
//   seg     out  [7:0]  {dp,g,f,e,d,c,b,a}, registered
//   an      out  [3:0]  active-low digit enables, registered
//   frame   out  one-cycle pulse after the digit3 slot completes, registered
//
// Optional build macro:
//   LEADZERO_BLANK_EN  suppress leading zero digits 3..1 (digit0 always shown);
//                      a suppressed digit with its dp set shows the dp alone.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module seg_scan_driver #(
    parameter int unsigned CLK_DIV        = 1000,
    parameter int unsigned BLANK_CYC      = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  dp,
    input  logic        load,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame
);

    localparam int unsigned     CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYC);
    localparam logic [7:0]      SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic {
        SLOT_BLANK,
        SLOT_SHOW
    } slot_e;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Registered state
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [1:0]    idx_q,    idx_d;
    logic [19:0]   pend_q,   pend_d;
    logic          pend_v_q, pend_v_d;
    logic [19:0]   act_q,    act_d;
    logic [7:0]    seg_q,    seg_d;
    logic [3:0]    an_q,     an_d;
    logic          frame_q,  frame_d;

    // Combinational helpers
    slot_e         slot;
    logic          slot_end;
    logic          boundary;
    logic [3:0]    act_nib;
    logic [3:0]    act_dp;
    logic          dp_bit;
    logic [7:0]    lit;
    logic [3:0]    an_on;
    logic          suppress;

    // Slot counter and digit index
    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        boundary = slot_end && (idx_q == 2'd3);
        cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
        slot     = (cnt_q < BLANK_END) ? SLOT_BLANK : SLOT_SHOW;
        frame_d  = boundary;
    end

    // Double buffer. A load that coincides with the boundary bypasses pending
    // and goes straight to active, otherwise it would be held a whole frame.
    always_comb begin
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        act_d    = act_q;
        if (boundary) begin
            if (load) begin
                act_d    = {dp, digits};
                pend_d   = {dp, digits};
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                act_d    = pend_q;
                pend_v_d = 1'b0;
            end
        end else if (load) begin
            pend_d   = {dp, digits};
            pend_v_d = 1'b1;
        end
    end

    // Output pattern for the digit currently being scanned
    always_comb begin
        act_nib = act_q[{idx_q, 2'b00} +: 4];
        act_dp  = act_q[19:16];
        dp_bit  = act_dp[idx_q];
        lit     = {dp_bit, hex_to_seg(act_nib)};
        an_on   = ~(4'b0001 << idx_q);
        suppress = 1'b0;
`ifdef LEADZERO_BLANK_EN
        // Digit k is a leading zero when it and every higher nibble are zero.
        case (idx_q)
            2'd3:    suppress = (act_q[15:12] == 4'h0);
            2'd2:    suppress = (act_q[15:8]  == 8'h00);
            2'd1:    suppress = (act_q[15:4]  == 12'h000);
            default: suppress = 1'b0;
        endcase
        if (suppress) begin
            lit = {dp_bit, 7'b0};
            if (!dp_bit) begin
                an_on = 4'hF;
            end
        end
`endif
        if (slot == SLOT_SHOW) begin
            an_d  = an_on;
            seg_d = SEG_ACTIVE_LOW ? ~lit : lit;
        end else begin
            an_d  = 4'hF;
            seg_d = SEG_OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            act_q    <= '0;
            seg_q    <= SEG_OFF;
            an_q     <= 4'hF;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            act_q    <= act_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            frame_q  <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule
